// File: rtl/rtc_read_sequencer_if.sv
// rtc_read_sequencer_if
//   Groups the RTC read sequencer's bus-side signals.
//   slave  : the sequencer (samples start/cnt/din, drives everything else)
//   master : the environment (drives start/cnt/din, observes the rest)
//   start         sweep request
//   cnt[6:0]      external transaction counter value
//   en_cnt        counter enable
//   din[7:0]      RTC data read back
//   ad_out[7:0]   address onto multiplexed AD bus, ad_oe its output enable
//   ale/cs_n/rd_n RTC bus strobes
//   seg..tmr      captured RTC registers
//   busy/done     sweep status
interface rtc_read_sequencer_if;
  logic       start;
  logic [6:0] cnt;
  logic       en_cnt;
  logic [7:0] din;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       ale;
  logic       cs_n;
  logic       rd_n;
  logic [7:0] seg;
  logic [7:0] min;
  logic [7:0] hr;
  logic [7:0] dia;
  logic [7:0] mes;
  logic [7:0] anio;
  logic [7:0] tmr;
  logic       busy;
  logic       done;

  modport slave (
    input  start, cnt, din,
    output en_cnt, ad_out, ad_oe, ale, cs_n, rd_n,
           seg, min, hr, dia, mes, anio, tmr, busy, done
  );

  modport master (
    output start, cnt, din,
    input  en_cnt, ad_out, ad_oe, ale, cs_n, rd_n,
           seg, min, hr, dia, mes, anio, tmr, busy, done
  );
endinterface

// File: rtl/rtc_read_sequencer.sv
// rtc_read_sequencer
//   Reads seven RTC registers in one sweep. Each register takes one
//   85-cycle transaction timed by an external counter (cnt 0..84 while
//   en_cnt is high). Strobes are decoded from cnt; din is captured at
//   cnt == SAMPLE_AT into the register selected by the sweep index.
//   clk   : system clock, rising edge
//   reset : asynchronous, active low
//   bus   : rtc_read_sequencer_if.slave (handshake, RTC bus, results)
module rtc_read_sequencer #(
  parameter int unsigned ALE_END   = 9,
  parameter int unsigned CS_START  = 20,
  parameter int unsigned RD_START  = 30,
  parameter int unsigned SAMPLE_AT = 60,
  parameter int unsigned RD_END    = 64,
  parameter int unsigned CS_END    = 74
) (
  input  logic                  clk,
  input  logic                  reset,
  rtc_read_sequencer_if.slave   bus
);

  localparam logic [6:0] LP_ALE_END   = 7'(ALE_END);
  localparam logic [6:0] LP_CS_START  = 7'(CS_START);
  localparam logic [6:0] LP_RD_START  = 7'(RD_START);
  localparam logic [6:0] LP_SAMPLE_AT = 7'(SAMPLE_AT);
  localparam logic [6:0] LP_RD_END    = 7'(RD_END);
  localparam logic [6:0] LP_CS_END    = 7'(CS_END);
  localparam logic [6:0] LP_CNT_LAST  = 7'd84;
  localparam logic [2:0] LP_IDX_LAST  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DONE
  } state_t;

  state_t     r_state;
  logic [2:0] r_idx;
  logic       r_busy;
  logic       r_done;
  logic [7:0] r_data [7];

  logic       w_in_read;
  logic [7:0] w_addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_data  <= '{default: '0};
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_state <= ST_READ;
            r_idx   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_READ: begin
          if (bus.cnt == LP_SAMPLE_AT) begin
            r_data[r_idx] <= bus.din;
          end
          // Last count of a transaction: advance to next register or finish
          if (bus.cnt == LP_CNT_LAST) begin
            if (r_idx == LP_IDX_LAST) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign w_in_read = (r_state == ST_READ);

  always_comb begin
    w_addr = 8'h00;
    if (w_in_read) begin
      case (r_idx)
        3'd0:    w_addr = 8'h21;
        3'd1:    w_addr = 8'h22;
        3'd2:    w_addr = 8'h23;
        3'd3:    w_addr = 8'h24;
        3'd4:    w_addr = 8'h25;
        3'd5:    w_addr = 8'h26;
        3'd6:    w_addr = 8'h41;
        default: w_addr = 8'h00;
      endcase
    end
  end

  assign bus.ad_out = w_addr;
  assign bus.ale    = w_in_read && (bus.cnt <= LP_ALE_END);
  assign bus.ad_oe  = w_in_read && (bus.cnt <  LP_CS_START);
  assign bus.cs_n   = !(w_in_read && (bus.cnt >= LP_CS_START) && (bus.cnt <= LP_CS_END));
  assign bus.rd_n   = !(w_in_read && (bus.cnt >= LP_RD_START) && (bus.cnt <= LP_RD_END));

  // busy is high exactly in READ, which is also when the counter runs
  assign bus.en_cnt = r_busy;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;

  assign bus.seg  = r_data[0];
  assign bus.min  = r_data[1];
  assign bus.hr   = r_data[2];
  assign bus.dia  = r_data[3];
  assign bus.mes  = r_data[4];
  assign bus.anio = r_data[5];
  assign bus.tmr  = r_data[6];

endmodule

// File: doc/rtc_read_sequencer.md
RTC_READ_SEQUENCER -- requirements
Module: rtc_read_sequencer

Interface
REQ-001 Parameter: ALE_END, default 9, last count value with ale high.
REQ-002 Parameter: CS_START, default 20, first count value with cs_n low.
REQ-003 Parameter: RD_START, default 30, first count value with rd_n low.
REQ-004 Parameter: SAMPLE_AT, default 60, count value whose closing clock edge captures din.
REQ-005 Parameter: RD_END, default 64, last count value with rd_n low.
REQ-006 Parameter: CS_END, default 74, last count value with cs_n low.
REQ-007 Port: clk, input, 1, single system clock; all state changes on the rising edge.
REQ-008 Port: reset, input, 1, asynchronous active-low reset.
REQ-009 Port: start, input, 1, request for one full read sweep; level sampled each edge.
REQ-010 Port: cnt, input, 7, current value from the external transaction counter.
REQ-011 Port: en_cnt, output, 1, enable to the transaction counter.
REQ-012 Port: din, input, 8, RTC data bus read value.
REQ-013 Port: ad_out, output, 8, address driven onto the multiplexed AD bus.
REQ-014 Port: ad_oe, output, 1, AD bus output enable.
REQ-015 Port: ale, cs_n, rd_n, output, 1 each, RTC bus strobes.
REQ-016 Port: seg, min, hr, dia, mes, anio, tmr, output, 8 each, captured RTC registers.
REQ-017 Port: busy, output, 1, sweep in progress.
REQ-018 Port: done, output, 1, one-cycle end-of-sweep pulse.

Function
REQ-019 The external counter's contract SHALL be: cnt holds 0 while en_cnt is 0; while en_cnt is 1, cnt counts 0..84, then wraps to 0 (85-cycle transaction).
REQ-020 The FSM SHALL have the states IDLE, READ and DONE.
REQ-021 IDLE -> READ SHALL occur on the edge where start=1; idx clears to 0.
REQ-022 In READ: en_cnt=1 and busy=1; in IDLE and DONE: en_cnt=0 and busy=0.
REQ-023 Address table by idx SHALL be 0..6 = 0x21, 0x22, 0x23, 0x24, 0x25, 0x26, 0x41; ad_out = table[idx] in READ, 0x00 otherwise.
REQ-024 In READ, the strobes SHALL be combinational decodes of cnt: ale=1 for cnt<=ALE_END; ad_oe=1 for cnt<CS_START; cs_n=0 for CS_START<=cnt<=CS_END; rd_n=0 for RD_START<=cnt<=RD_END.
REQ-025 Outside READ, the strobes SHALL be idle: ale=0, ad_oe=0, cs_n=1, rd_n=1.
REQ-026 On the edge where state=READ and cnt==SAMPLE_AT, din SHALL load the output selected by idx: 0 seg, 1 min, 2 hr, 3 dia, 4 mes, 5 anio, 6 tmr.
REQ-027 On the edge where state=READ and cnt==84: if idx<6, idx increments and the state stays READ; if idx==6, the state goes to DONE.
REQ-028 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-029 start SHALL be ignored in READ and DONE; no queuing; a new sweep needs start=1 while in IDLE.
REQ-030 A full sweep SHALL be 7x85=595 READ cycles, with done in cycle 596 after the start edge.
REQ-031 Captured registers SHALL hold their value between sweeps; an unrelated idx never disturbs them.

Reset
REQ-032 With reset=0, the block SHALL asynchronously enter IDLE with idx=0, all seven data outputs 0x00, done=0, busy=0, en_cnt=0, ad_out=0x00, ad_oe=0, ale=0, cs_n=1 and rd_n=1.
REQ-033 reset asserted mid-sweep SHALL abort it immediately with no done pulse; the partially captured registers SHALL clear to 0x00.
REQ-034 After reset releases, the block SHALL wait in IDLE for start.

Verification
REQ-035 Scenario: reset, then start pulse, with din=0x37 constant -> all seven outputs 0x37, done high exactly at cycle 596, busy high 595 cycles.
REQ-036 Scenario: din = cnt-tagged pattern (0x10+idx) -> seg=0x10..tmr=0x16; ad_out sequence 0x21..0x26,0x41, changing only at cnt 84->0.
REQ-037 Scenario: strobe timing check on sweep 1 -> ale high cnt 0..9, ad_oe high 0..19, cs_n low 20..74, rd_n low 30..64.
REQ-038 Scenario: start held high continuously -> back-to-back sweeps separated by exactly one DONE and one IDLE cycle; no extra starts mid-sweep.
REQ-039 Scenario: reset asserted at idx=3, cnt=40 -> outputs immediately at reset values, no done, all data 0x00, en_cnt=0.
REQ-040 Scenario: start pulse during DONE cycle -> ignored; block idles until next start.
